// File: rtl/pipe_sequencer.sv
// -----------------------------------------------------------------------------
// pipe_sequencer
// Run-control and hazard sequencer for the 5-stage 16-bit pipeline.
//   - Run FSM (IDLE/RUN/DRAIN/HALTED) that drives the pipeline `state` input.
//   - Load-use hazard detection producing stall (bubble) and flush controls.
//   - Drains the pipe for three cycles after HALT or stop before halting.
//   - Optional performance counters, built only when PIPE_PERF_CNT_EN is
//     defined; otherwise the counter outputs are tied to zero.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   run request (level)
//   stop       in   soft-halt request (level)
//   id_ir      in   [15:0] instruction in ID
//   ex_ir      in   [15:0] instruction in EX
//   wb_ir      in   [15:0] instruction in WB
//   jump       in   taken branch/jump resolved this cycle
//   state      out  exec in RUN/DRAIN, idle otherwise (registered)
//   fetch_en   out  PC/IF advance enable (combinational)
//   stall      out  hold PC and IF/ID, bubble into EX (combinational)
//   flush      out  squash IF/ID and ID/EX (combinational)
//   halted     out  high in HALTED (registered)
//   cyc_cnt    out  [15:0] cycles spent in RUN/DRAIN (saturating)
//   ret_cnt    out  [15:0] non-zero instructions reaching WB (saturating)
//   stall_cnt  out  [15:0] load-use stall cycles (saturating)
// -----------------------------------------------------------------------------
module pipe_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] id_ir,
  input  logic [15:0] ex_ir,
  input  logic [15:0] wb_ir,
  input  logic        jump,
  output logic        state,
  output logic        fetch_en,
  output logic        stall,
  output logic        flush,
  output logic        halted,
  output logic [15:0] cyc_cnt,
  output logic [15:0] ret_cnt,
  output logic [15:0] stall_cnt
);

  // Opcode map of the pipeline ISA (instruction bits [15:11]).
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  localparam logic ST_EXEC = 1'b1;
  localparam logic ST_IDLE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } fsm_t;

  fsm_t       fsm_r;
  logic [1:0] drain_cnt_r;
  logic       state_r;
  logic       halted_r;

  logic       use_hi_s, use_mid_s, use_lo_s;
  logic       hazard_s;
  logic       active_s;
  logic       stall_s;
  logic       halt_in_id_s;
  logic [4:0] id_op_s;
  logic [2:0] load_dst_s;

  assign id_op_s      = id_ir[15:11];
  assign load_dst_s   = ex_ir[10:8];
  assign halt_in_id_s = (id_op_s == OP_HALT);
  assign active_s     = (fsm_r == S_RUN) || (fsm_r == S_DRAIN);

  // Which register fields of the ID instruction are read as sources.
  always_comb begin
    use_hi_s  = 1'b0;
    use_mid_s = 1'b0;
    use_lo_s  = 1'b0;
    case (id_op_s)
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC,
      OP_JMPR, OP_ADDI, OP_SUBI, OP_LDIH:  use_hi_s = 1'b1;
      OP_STORE: begin
        use_hi_s  = 1'b1;
        use_mid_s = 1'b1;
      end
      OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA: use_mid_s = 1'b1;
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
      OP_CMP, OP_AND, OP_OR, OP_XOR: begin
        use_mid_s = 1'b1;
        use_lo_s  = 1'b1;
      end
      default: begin
        use_hi_s  = 1'b0;
        use_mid_s = 1'b0;
        use_lo_s  = 1'b0;
      end
    endcase
  end

  // Load-use hazard: a LOAD in EX whose destination is read by ID.
  always_comb begin
    if (ex_ir[15:11] == OP_LOAD) begin
      hazard_s = (use_hi_s  && (id_ir[10:8] == load_dst_s)) ||
                 (use_mid_s && (id_ir[6:4]  == load_dst_s)) ||
                 (use_lo_s  && (id_ir[2:0]  == load_dst_s));
    end else begin
      hazard_s = 1'b0;
    end
  end

  // A taken jump squashes the dependent instruction, so flush beats stall.
  assign stall_s  = hazard_s && active_s && !jump;
  assign stall    = stall_s;
  assign flush    = jump && active_s;
  assign fetch_en = (fsm_r == S_RUN) && !stall_s;
  assign state    = state_r;
  assign halted   = halted_r;

  // Run FSM with registered state/halted outputs and the drain counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_r       <= S_IDLE;
      drain_cnt_r <= 2'd0;
      state_r     <= ST_IDLE;
      halted_r    <= 1'b0;
    end else begin
      case (fsm_r)
        S_IDLE, S_HALTED: begin
          if (start) begin
            fsm_r    <= S_RUN;
            state_r  <= ST_EXEC;
            halted_r <= 1'b0;
          end
        end
        S_RUN: begin
          // stop wins over start; a HALT under a taken jump is squashed.
          if (stop || (halt_in_id_s && !jump)) begin
            fsm_r       <= S_DRAIN;
            drain_cnt_r <= 2'd3;
          end
        end
        S_DRAIN: begin
          // Counter reaches 0 on the edge that enters HALTED: three DRAIN cycles.
          if (drain_cnt_r <= 2'd1) begin
            fsm_r       <= S_HALTED;
            drain_cnt_r <= 2'd0;
            state_r     <= ST_IDLE;
            halted_r    <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r - 2'd1;
          end
        end
        default: begin
          fsm_r       <= S_IDLE;
          drain_cnt_r <= 2'd0;
          state_r     <= ST_IDLE;
          halted_r    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] cyc_cnt_r, ret_cnt_r, stall_cnt_r;
  logic        cnt_clear_s;
  logic        unused_bits_s;

  assign cnt_clear_s   = ((fsm_r == S_IDLE) || (fsm_r == S_HALTED)) && start;
  assign unused_bits_s = ^{ex_ir[7:0], id_ir[7], id_ir[3]};

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? (v + 16'd1) : v;
  endfunction

  // Saturating performance counters; cleared on every entry to RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_cnt_r   <= 16'h0000;
      ret_cnt_r   <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else if (cnt_clear_s) begin
      cyc_cnt_r   <= 16'h0000;
      ret_cnt_r   <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else if (active_s) begin
      cyc_cnt_r   <= sat_inc(cyc_cnt_r, 1'b1);
      ret_cnt_r   <= sat_inc(ret_cnt_r, wb_ir != 16'h0000);
      stall_cnt_r <= sat_inc(stall_cnt_r, stall_s);
    end
  end

  assign cyc_cnt   = cyc_cnt_r;
  assign ret_cnt   = ret_cnt_r;
  assign stall_cnt = stall_cnt_r;
`else
  logic unused_bits_s;
  assign unused_bits_s = ^{wb_ir, ex_ir[7:0], id_ir[7], id_ir[3]};
  assign cyc_cnt   = 16'h0000;
  assign ret_cnt   = 16'h0000;
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipe_sequencer
// Directed stimulus for pipe_sequencer. Each driven cycle pushes its expected
// outputs into a queue; a monitor on the falling edge pops and compares.
// Counter expectations collapse to zero when PIPE_PERF_CNT_EN is undefined.
// -----------------------------------------------------------------------------
module tb_pipe_sequencer;

  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b01000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        jump  = 1'b0;
  logic [15:0] id_ir = 16'h0000;
  logic [15:0] ex_ir = 16'h0000;
  logic [15:0] wb_ir = 16'h0000;
  logic        state, fetch_en, stall, flush, halted;
  logic [15:0] cyc_cnt, ret_cnt, stall_cnt;

  pipe_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .id_ir(id_ir), .ex_ir(ex_ir), .wb_ir(wb_ir), .jump(jump),
    .state(state), .fetch_en(fetch_en), .stall(stall), .flush(flush),
    .halted(halted), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [52:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [15:0] mk(input logic [4:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic [2:0] c);
    return {op, a, 1'b0, b, 1'b0, c};
  endfunction

  function automatic logic [15:0] ec(input logic [15:0] v);
`ifdef PIPE_PERF_CNT_EN
    return v;
`else
    return (v == 16'hFFFF) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  // flags = {state, fetch_en, stall, flush, halted}
  task automatic drive(input string name, input logic rs, input logic st, input logic sp,
                       input logic jp, input logic [15:0] id, input logic [15:0] ex,
                       input logic [15:0] wb, input logic [4:0] flags,
                       input logic [15:0] c, input logic [15:0] r, input logic [15:0] s,
                       input bit chk);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rs; start = st; stop = sp; jump = jp;
    id_ir = id; ex_ir = ex; wb_ir = wb;
    if (chk) begin
      e.name = name;
      e.exp  = {flags, ec(c), ec(r), ec(s)};
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clock) begin
    exp_t        e;
    logic [52:0] got;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = {state, fetch_en, stall, flush, halted, cyc_cnt, ret_cnt, stall_cnt};
      n_total++;
      if (got === e.exp) n_pass++;
      else $display("FAIL %s: got %h required %h (st,fe,stl,fl,hlt,cyc,ret,stlcnt)",
                    e.name, got, e.exp);
    end
  end

  logic [15:0] add_r3, add_r4, ld_r3, ld_r2, ld_r5, st_r2, ld_use5, halt_i;
  logic [9:0]  wb_pat;
  int          ret_exp;

  initial begin
    add_r3  = mk(OP_ADD, 3'd1, 3'd2, 3'd3);
    add_r4  = mk(OP_ADD, 3'd1, 3'd2, 3'd4);
    ld_r3   = mk(OP_LOAD, 3'd3, 3'd0, 3'd0);
    ld_r2   = mk(OP_LOAD, 3'd2, 3'd0, 3'd0);
    ld_r5   = mk(OP_LOAD, 3'd5, 3'd0, 3'd0);
    ld_use5 = mk(OP_LOAD, 3'd1, 3'd5, 3'd0);
    st_r2   = mk(OP_STORE, 3'd2, 3'd5, 3'd0);
    halt_i  = mk(OP_HALT, 3'd0, 3'd0, 3'd0);
    wb_pat  = 10'b1101101101;

    #2 reset = 1'b1;
    //     name            rs   st   sp   jp   id       ex     wb     flags     cyc     ret    stl
    drive("reset",        1'b1,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b00000, 16'd0,  16'd0, 16'd0, 1);
    drive("idle",         1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b00000, 16'd0,  16'd0, 16'd0, 1);
    drive("idle_start",   1'b0,1'b1,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b00000, 16'd0,  16'd0, 16'd0, 1);
    drive("run_entry",    1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b11000, 16'd0,  16'd0, 16'd0, 1);
    drive("ld_use_add",   1'b0,1'b0,1'b0,1'b0,add_r3,  ld_r3, 16'h0, 5'b10100, 16'd1,  16'd0, 16'd0, 1);
    drive("stall_clears", 1'b0,1'b0,1'b0,1'b0,add_r3,  16'h0, 16'h0, 5'b11000, 16'd2,  16'd0, 16'd1, 1);
    drive("no_hazard",    1'b0,1'b0,1'b0,1'b0,add_r4,  ld_r3, 16'h0, 5'b11000, 16'd3,  16'd0, 16'd1, 1);
    drive("store_smdr",   1'b0,1'b0,1'b0,1'b0,st_r2,   ld_r2, 16'h0, 5'b10100, 16'd4,  16'd0, 16'd1, 1);
    drive("hazard_jump",  1'b0,1'b0,1'b0,1'b1,st_r2,   ld_r2, 16'h0, 5'b11010, 16'd5,  16'd0, 16'd2, 1);
    drive("load_base",    1'b0,1'b0,1'b0,1'b0,ld_use5, ld_r5, 16'h0, 5'b10100, 16'd6,  16'd0, 16'd2, 1);
    drive("halt_squash",  1'b0,1'b0,1'b0,1'b1,halt_i,  16'h0, 16'h0, 5'b11010, 16'd7,  16'd0, 16'd3, 1);
    drive("halt_in_id",   1'b0,1'b0,1'b0,1'b0,halt_i,  16'h0, 16'h0, 5'b11000, 16'd8,  16'd0, 16'd3, 1);
    drive("drain1",       1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b10000, 16'd9,  16'd0, 16'd3, 1);
    drive("drain2_jump",  1'b0,1'b0,1'b0,1'b1,16'h0,   16'h0, 16'h0, 5'b10010, 16'd10, 16'd0, 16'd3, 1);
    drive("drain3_stall", 1'b0,1'b0,1'b0,1'b0,add_r3,  ld_r3, 16'h0, 5'b10100, 16'd11, 16'd0, 16'd3, 1);
    drive("halted_stop",  1'b0,1'b0,1'b1,1'b1,add_r3,  ld_r3, 16'h0, 5'b00001, 16'd12, 16'd0, 16'd4, 1);
    drive("halted_both",  1'b0,1'b1,1'b1,1'b0,16'h0,   16'h0, 16'h0, 5'b00001, 16'd12, 16'd0, 16'd4, 1);
    drive("rerun_clear",  1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b11000, 16'd0,  16'd0, 16'd0, 1);
    drive("run_both",     1'b0,1'b1,1'b1,1'b0,16'h0,   16'h0, 16'h0, 5'b11000, 16'd1,  16'd0, 16'd0, 1);
    drive("stop_drain",   1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b10000, 16'd2,  16'd0, 16'd0, 1);
    drive("reset_drain",  1'b1,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b00000, 16'd0,  16'd0, 16'd0, 1);
    drive("post_reset",   1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b00000, 16'd0,  16'd0, 16'd0, 1);
    drive("start_ret",    1'b0,1'b1,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b00000, 16'd0,  16'd0, 16'd0, 1);

    // Ten RUN cycles, seven of them retire a non-zero instruction.
    ret_exp = 0;
    for (int i = 0; i < 10; i++) begin
      drive("ret_run", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, wb_pat[i] ? 16'h1234 : 16'h0,
            5'b11000, 16'(i), 16'(ret_exp), 16'd0, 1);
      if (wb_pat[i]) ret_exp++;
    end
    drive("ret_total",    1'b0,1'b0,1'b1,1'b0,16'h0,   16'h0, 16'h0, 5'b11000, 16'd10, 16'd7, 16'd0, 1);
    drive("ret_drain1",   1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b10000, 16'd11, 16'd7, 16'd0, 1);
    drive("ret_drain2",   1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b10000, 16'd12, 16'd7, 16'd0, 1);
    drive("ret_drain3",   1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b10000, 16'd13, 16'd7, 16'd0, 1);
    drive("ret_halted",   1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h1, 5'b00001, 16'd14, 16'd7, 16'd0, 1);
    drive("ret_hold",     1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h1, 5'b00001, 16'd14, 16'd7, 16'd0, 1);

`ifdef PIPE_PERF_CNT_EN
    // Saturation: run until the counters pass 16'hFFFF.
    drive("sat_start",    1'b0,1'b1,1'b0,1'b0,16'h0,   16'h0, 16'h0, 5'b00001, 16'd14, 16'd7, 16'd0, 1);
    for (int i = 0; i < 65533; i++) begin
      drive("sat_fill", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h1, 5'b11000,
            16'd0, 16'd0, 16'd0, 0);
    end
    drive("sat_fffd",     1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h1, 5'b11000, 16'hFFFD, 16'hFFFD, 16'd0, 1);
    drive("sat_fffe",     1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h1, 5'b11000, 16'hFFFE, 16'hFFFE, 16'd0, 1);
    drive("sat_ffff",     1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h1, 5'b11000, 16'hFFFF, 16'hFFFF, 16'd0, 1);
    drive("sat_hold",     1'b0,1'b0,1'b0,1'b0,16'h0,   16'h0, 16'h1, 5'b11000, 16'hFFFF, 16'hFFFF, 16'd0, 1);
`endif

    // Let the monitor drain the queue, bounded.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clock);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_queue: got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Run-control and hazard sequencer for the 5-stage 16-bit pipeline. Owns the run state machine that drives the `state` input of IF/ID/EX/MEM/WB. Detects load-use hazards the ID forwarding network cannot cover and issues the stall, bubble and flush controls. Also drains the pipe on HALT and keeps optional performance counters.

## Interface
- No parameters; opcodes come from `define.v` (`` `LOAD``, `` `STORE``, `` `HALT``, ALU/branch opcodes, `` `exec``/`` `idle``).
- `clock` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: run request; level sampled each cycle.
- `stop` in 1: soft-halt request; level sampled each cycle.
- `id_ir` in 16: instruction in ID.
- `ex_ir` in 16: instruction in EX.
- `wb_ir` in 16: instruction in WB.
- `jump` in 1: taken branch/jump resolved this cycle.
- `state` out 1: `` `exec`` in RUN and DRAIN, else `` `idle``.
- `fetch_en` out 1: PC/IF advance enable.
- `stall` out 1: hold PC and IF/ID; ID must load `ex_ir <= 0` (bubble).
- `flush` out 1: squash IF/ID and ID/EX.
- `halted` out 1: high in HALTED.
- `cyc_cnt`, `ret_cnt`, `stall_cnt` out 16 each: performance counters.

## Operation
- States: IDLE, RUN, DRAIN, HALTED. State is registered.
- IDLE: `start`=1 → RUN. On this transition all counters clear.
- RUN:
  - `stop`=1 → DRAIN.
  - `id_ir[15:11]`==`` `HALT`` with `jump`=0 → DRAIN.
  - A HALT in ID with `jump`=1 is squashed and stays in RUN.
- DRAIN:
  - `fetch_en`=0. The 2-bit drain counter loads 3 on entry and decrements each cycle.
  - At 0 → HALTED.
  - `jump` in DRAIN still drives `flush`; the counter is unaffected.
- HALTED: `start`=1 → RUN and counters clear. `stop` is ignored.
- `reset` from any state → IDLE immediately, mid-drain included.
- Load-use hazard: `ex_ir[15:11]`==`` `LOAD``, with d=`ex_ir[10:8]`, and any source of `id_ir` equals d. Sources of `id_ir`:
  - `[10:8]`: BZ/BNZ/BN/BNN/BC/BNC/JMPR/ADDI/SUBI/LDIH/STORE.
  - `[6:4]`: LOAD/STORE/ADD/ADDC/SUB/SUBC/CMP/AND/OR/XOR/SLL/SRL/SLA/SRA.
  - `[2:0]`: ADD/ADDC/SUB/SUBC/CMP/AND/OR/XOR.
- `stall` = hazard & (state RUN or DRAIN) & !`jump`. `flush` wins over `stall`.
- `fetch_en` = (state==RUN) & !`stall`.
- `flush` = `jump` & (state RUN or DRAIN).
- Counters:
  - `cyc_cnt` increments every cycle in RUN/DRAIN.
  - `ret_cnt` increments when `wb_ir`≠16'h0000.
  - `stall_cnt` increments when `stall`=1.
  - All saturate at 16'hFFFF and hold their value in IDLE/HALTED.

## Timing
- Reset values: state IDLE, `state`=`` `idle``, `fetch_en`=0, `stall`=0, `flush`=0, `halted`=0, all counters 0.
- `stall`, `flush` and `fetch_en` are combinational from current inputs and registered state, with no added latency. Consumers sample them on the same rising edge.
- A load-use stall lasts exactly 1 cycle. Next cycle the LOAD is in MEM and `ex_ir` is a bubble, so the hazard clears by itself.
- `start` high in IDLE at edge N: `state`=`` `exec`` and `fetch_en`=1 from cycle N+1.
- HALT decoded in ID at edge N: DRAIN during N+1..N+3, `halted`=1 from N+4.
- `start` and `stop` both high in IDLE/HALTED: `start` wins. Both high in RUN: `stop` wins.
- Counters update on the edge that ends the counted cycle.

## Configuration
- `PIPE_PERF_CNT_EN` defined: the three counters and their saturation logic are built.
- Undefined: `cyc_cnt`, `ret_cnt` and `stall_cnt` are tied to 16'h0000 and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset mid-DRAIN (count=2): assert `reset` → same-cycle `state`=`` `idle``, `halted`=0, `fetch_en`=0, counters 0.
- RUN, `ex_ir`=LOAD r3, `id_ir`=ADD r1,r2,r3 → `stall`=1, `fetch_en`=0 for exactly 1 cycle. `stall_cnt` 0→1.
- RUN, `ex_ir`=LOAD r3, `id_ir`=ADD r1,r2,r4 → `stall`=0.
- RUN, `ex_ir`=LOAD r2, `id_ir`=STORE r2,r5,0 → `stall`=1, because the smdr source uses `[10:8]`.
- Same hazard with `jump`=1 → `flush`=1, `stall`=0.
- `id_ir`=HALT at edge N → `fetch_en`=0 at N+1, `halted`=1 at N+4. Then `start`=1 → RUN and `cyc_cnt`=0.
- `PIPE_PERF_CNT_EN` on: run 10 cycles in RUN with 7 non-zero `wb_ir` → `cyc_cnt`=10, `ret_cnt`=7. Preload `cyc_cnt` near 16'hFFFF → it holds at 16'hFFFF.
